ddr_act_scheduler: RTL and testbench
====================================

// Module: ddr_act_scheduler
// PURPOSE
// - Row-activation stage of the DDR4 controller. Sits between the host request queue and the CAS/RW stage.
// - Accepts one request at a time and tracks the open row of every bank (open-page policy).
// - Issues PRE and/or ACT as needed, honouring tRP, tRCD, tRRD and tRAS.
// - Hands the request to the CAS stage once the row is open and tRCD has elapsed.
// PARAMETERS
// - ROW_W  15  row address width
// - COL_W  10  column address width
// - T_RCD  16  ACT-to-handoff delay in clocks, >=1
// - T_RP   16  PRE-to-ACT delay in clocks, >=1
// - T_RRD   4  min clocks between any two ACTs, >=1
// - T_RAS  39  min clocks from ACT to PRE on the same bank, >=1
// PORTS
// - clock        in   1      controller clock, all logic posedge
// - reset        in   1      synchronous, active-high
// - config_done  in   1      MRS init complete; no request accepted while 0
// - req_valid    in   1      request present
// - req_rdy      out  1      request accepted when req_valid&&req_rdy
// - req_rw       in   2      2'b01 write, 2'b10 read; other codes not produced by upstream
// - req_bg       in   2      bank group
// - req_ba       in   2      bank
// - req_row      in   ROW_W  row
// - req_col      in   COL_W  column
// - cmd_valid    out  1      one-cycle pulse: command on cmd_* this cycle
// - cmd_type     out  2      2'b01 ACT, 2'b10 PRE, 2'b00 none
// - cmd_bg/ba    out  2/2    command bank group/bank
// - cmd_row      out  ROW_W  row for ACT, 0 for PRE
// - cas_valid    out  1      request ready for CAS stage
// - cas_rdy      in   1      CAS stage accepts when cas_valid&&cas_rdy
// - cas_rw       out  2      copy of req_rw
// - cas_bg/ba    out  2/2    bank group/bank
// - cas_col      out  COL_W  column
// - act_idle     out  1      1 in IDLE with no request held
// BEHAVIOUR
// - Reset: all outputs 0 except act_idle=1.
// - Reset also clears all open-row valid bits, zeroes all timers and enters IDLE.
// - Reset mid-operation discards the held request; no partial command is issued.
// - req_rdy = (state==IDLE) && config_done.
// - Request fields are latched on acceptance. Bank index = {bg,ba} (16 banks).
// - FSM: IDLE -> CHECK (1 cycle after accept).
// - CHECK, row hit (open and row equal): -> HANDOFF.
// - CHECK, bank closed: -> ACT.
// - CHECK, bank open with a different row: -> PRE.
// - PRE: wait until the bank's tRAS timer is 0, then pulse cmd PRE.
//   Clear the bank's valid bit, load the tRP counter, -> WAIT_RP.
// - WAIT_RP: count T_RP cycles from the PRE pulse, then -> ACT.
// - ACT: wait until the global tRRD timer is 0, then pulse cmd ACT.
//   Record the row as open, load bank tRAS=T_RAS, global tRRD=T_RRD and tRCD=T_RCD, -> WAIT_RCD.
// - WAIT_RCD: cas_valid is asserted exactly T_RCD cycles after the ACT pulse, -> HANDOFF.
// - HANDOFF: cas_valid=1 and cas_* stable until cas_rdy. On cas_rdy -> IDLE, cas_valid drops next cycle.
// - Row hit latency: accept at cycle N -> cas_valid at cycle N+2.
// - Timers: saturating down-counters, decrement every cycle independent of FSM state.
//   Width $clog2(max param)+1.
// - tRRD and tRAS are satisfied when the timer reads 0.
// - At most one cmd_valid pulse per cycle. No back-to-back acceptance: next accept is the cycle after the handoff completes.
// - cas_rdy held high before cas_valid has no effect. A cas_rdy pulse outside HANDOFF is ignored.
// - config_done falling while busy: the current request completes; no new accept.
// - Assertions: cmd_valid implies cmd_type!=0; cas_* stable while cas_valid&&!cas_rdy.
// STRUCTURE
// - ddr_package.pkg gets: act_cmd_e {CMD_NONE, CMD_ACT, CMD_PRE},
//   bank_state_t {valid, row}, NUM_BANKS=16, RW_WRITE=2'b01, RW_READ=2'b10.
// - Timing defaults are declared there too.
// - One sub-module: ddr_bank_table.
//   Holds the 16 x {valid,row} table and the 16 tRAS timers.
//   Read port: combinational lookup by bank index. Write port: open/close.
// - The FSM and the tRP, tRCD and tRRD timers live in this module.
// TESTING
// - Row hit: open bg0/ba0 row 5, then request bg0/ba0 row 5 read -> no cmd, cas_valid 2 cycles after accept, cas_rw=2'b10.
// - Closed bank: write to bg1/ba2 row 0x1A -> ACT (cmd_bg=1, ba=2, row=0x1A) 2 cycles after accept.
//   cas_valid exactly 16 cycles after the ACT.
// - Row miss: bank open at row 3, then request row 4 -> PRE no earlier than 39 cycles after the original ACT.
//   ACT 16 cycles after the PRE, cas_valid 16 cycles after that ACT.
// - tRRD: ACT bank0, handoff immediately, request closed bank1 -> second ACT at least 4 cycles after the first.
// - Backpressure: hold cas_rdy=0 for 10 cycles -> cas_valid and cas_* stable, req_rdy=0.
//   cas_rdy=1 -> req_rdy=1 the next cycle.
// - Reset during WAIT_RCD -> all outputs at reset values next cycle.
//   A request to the same row then issues a fresh ACT, since no row is open.

Source files
------------

// File: rtl/ddr_act_scheduler_pkg.sv
// Shared types, defaults and helpers for the DDR4 row-activation stage.
package ddr_act_scheduler_pkg;

  localparam int DEF_ROW_W = 15;
  localparam int DEF_COL_W = 10;
  localparam int DEF_T_RCD = 16;
  localparam int DEF_T_RP  = 16;
  localparam int DEF_T_RRD = 4;
  localparam int DEF_T_RAS = 39;

  localparam int NUM_BANKS = 16;
  localparam int BANK_W    = 4;

  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_ACT  = 2'b01,
    CMD_PRE  = 2'b10
  } act_cmd_e;

  typedef struct packed {
    logic                 valid;
    logic [DEF_ROW_W-1:0] row;
  } bank_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_HANDOFF
  } act_state_e;

  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ddr_bank_table.sv
// Per-bank open-row table plus per-bank tRAS timers; combinational read,
// single open/close write per cycle.
module ddr_bank_table
  import ddr_act_scheduler_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int TW    = 7,
  parameter int T_RAS = DEF_T_RAS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BANK_W-1:0] rd_idx_i,
  output logic              rd_valid_o,
  output logic [ROW_W-1:0]  rd_row_o,
  output logic              rd_tras_zero_o,
  input  logic              open_i,
  input  logic              close_i,
  input  logic [BANK_W-1:0] wr_idx_i,
  input  logic [ROW_W-1:0]  wr_row_i
);

  bank_state_t       tbl_q  [NUM_BANKS];
  bank_state_t       tbl_d  [NUM_BANKS];
  logic [TW-1:0]     tras_q [NUM_BANKS];
  logic [TW-1:0]     tras_d [NUM_BANKS];

  assign rd_valid_o     = tbl_q[rd_idx_i].valid;
  assign rd_row_o       = ROW_W'(tbl_q[rd_idx_i].row);
  assign rd_tras_zero_o = (tras_q[rd_idx_i] == '0);

  // Loading T_RAS-1 makes the earliest PRE land exactly T_RAS clocks after the ACT.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      tbl_d[i]  = tbl_q[i];
      tras_d[i] = (tras_q[i] != '0) ? tras_q[i] - TW'(1) : '0;
    end
    if (open_i) begin
      tbl_d[wr_idx_i]  = {1'b1, DEF_ROW_W'(wr_row_i)};
      tras_d[wr_idx_i] = TW'(T_RAS - 1);
    end else if (close_i) begin
      tbl_d[wr_idx_i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rst_i) begin
        tbl_q[i]  <= '0;
        tras_q[i] <= '0;
      end else begin
        tbl_q[i]  <= tbl_d[i];
        tras_q[i] <= tras_d[i];
      end
    end
  end

endmodule

// File: rtl/ddr_act_scheduler.sv
// Row-activation stage: one request at a time, open-page policy, issues
// PRE/ACT under tRP/tRCD/tRRD/tRAS and hands the request to the CAS stage.
module ddr_act_scheduler
  import ddr_act_scheduler_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RRD = DEF_T_RRD,
  parameter int T_RAS = DEF_T_RAS
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             config_done_i,
  input  logic             req_valid_i,
  output logic             req_rdy_o,
  input  logic [1:0]       req_rw_i,
  input  logic [1:0]       req_bg_i,
  input  logic [1:0]       req_ba_i,
  input  logic [ROW_W-1:0] req_row_i,
  input  logic [COL_W-1:0] req_col_i,
  output logic             cmd_valid_o,
  output logic [1:0]       cmd_type_o,
  output logic [1:0]       cmd_bg_o,
  output logic [1:0]       cmd_ba_o,
  output logic [ROW_W-1:0] cmd_row_o,
  output logic             cas_valid_o,
  input  logic             cas_rdy_i,
  output logic [1:0]       cas_rw_o,
  output logic [1:0]       cas_bg_o,
  output logic [1:0]       cas_ba_o,
  output logic [COL_W-1:0] cas_col_o,
  output logic             act_idle_o
);

  localparam int TW = timer_width(T_RCD, T_RP, T_RRD, T_RAS);

  act_state_e       state_q, state_d;
  logic [1:0]       rw_q, rw_d, bg_q, bg_d, ba_q, ba_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [TW-1:0]    trp_q, trp_d, trcd_q, trcd_d, trrd_q, trrd_d;

  act_cmd_e         cmd_type;
  logic             open_en, close_en;
  logic             bank_valid, tras_zero;
  logic [ROW_W-1:0] bank_row;

  ddr_bank_table #(
    .ROW_W (ROW_W),
    .TW    (TW),
    .T_RAS (T_RAS)
  ) u_bank_table (
    .clk_i          (clock_i),
    .rst_i          (reset_i),
    .rd_idx_i       ({bg_q, ba_q}),
    .rd_valid_o     (bank_valid),
    .rd_row_o       (bank_row),
    .rd_tras_zero_o (tras_zero),
    .open_i         (open_en),
    .close_i        (close_en),
    .wr_idx_i       ({bg_q, ba_q}),
    .wr_row_i       (row_q)
  );

  // Wait timers are loaded with T-1 and released at <=1 so the next state
  // begins exactly T clocks after the command pulse.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    bg_d     = bg_q;
    ba_d     = ba_q;
    row_d    = row_q;
    col_d    = col_q;
    trp_d    = (trp_q  != '0) ? trp_q  - TW'(1) : '0;
    trcd_d   = (trcd_q != '0) ? trcd_q - TW'(1) : '0;
    trrd_d   = (trrd_q != '0) ? trrd_q - TW'(1) : '0;
    cmd_type = CMD_NONE;
    open_en  = 1'b0;
    close_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && config_done_i) begin
          rw_d    = req_rw_i;
          bg_d    = req_bg_i;
          ba_d    = req_ba_i;
          row_d   = req_row_i;
          col_d   = req_col_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bank_valid && (bank_row == row_q)) state_d = ST_HANDOFF;
        else if (!bank_valid)                  state_d = ST_ACT;
        else                                   state_d = ST_PRE;
      end
      ST_PRE: begin
        if (tras_zero) begin
          cmd_type = CMD_PRE;
          close_en = 1'b1;
          trp_d    = TW'(T_RP - 1);
          state_d  = (T_RP == 1) ? ST_ACT : ST_WAIT_RP;
        end
      end
      ST_WAIT_RP: begin
        if (trp_q <= TW'(1)) state_d = ST_ACT;
      end
      ST_ACT: begin
        if (trrd_q == '0) begin
          cmd_type = CMD_ACT;
          open_en  = 1'b1;
          trrd_d   = TW'(T_RRD - 1);
          trcd_d   = TW'(T_RCD - 1);
          state_d  = (T_RCD == 1) ? ST_HANDOFF : ST_WAIT_RCD;
        end
      end
      ST_WAIT_RCD: begin
        if (trcd_q <= TW'(1)) state_d = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (cas_rdy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      rw_q    <= '0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      trp_q   <= '0;
      trcd_q  <= '0;
      trrd_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      trp_q   <= trp_d;
      trcd_q  <= trcd_d;
      trrd_q  <= trrd_d;
    end
  end

  assign req_rdy_o   = (state_q == ST_IDLE) && config_done_i;
  assign act_idle_o  = (state_q == ST_IDLE);
  assign cmd_valid_o = (cmd_type != CMD_NONE);
  assign cmd_type_o  = cmd_type;
  assign cmd_bg_o    = cmd_valid_o ? bg_q : 2'b00;
  assign cmd_ba_o    = cmd_valid_o ? ba_q : 2'b00;
  assign cmd_row_o   = (cmd_type == CMD_ACT) ? row_q : '0;
  assign cas_valid_o = (state_q == ST_HANDOFF);
  assign cas_rw_o    = cas_valid_o ? rw_q  : 2'b00;
  assign cas_bg_o    = cas_valid_o ? bg_q  : 2'b00;
  assign cas_ba_o    = cas_valid_o ? ba_q  : 2'b00;
  assign cas_col_o   = cas_valid_o ? col_q : '0;

  a_cmd_type: assert property (@(posedge clock_i) disable iff (reset_i)
    cmd_valid_o |-> (cmd_type_o != 2'b00));

  a_cas_stable: assert property (@(posedge clock_i) disable iff (reset_i)
    (cas_valid_o && !cas_rdy_i) |=>
      (cas_valid_o && $stable({cas_rw_o, cas_bg_o, cas_ba_o, cas_col_o})));

endmodule

// File: tb/tb_ddr_act_scheduler.sv
module tb_ddr_act_scheduler;
  import ddr_act_scheduler_pkg::*;

  localparam int ROW_W = 15;
  localparam int COL_W = 10;
  localparam int T_RCD = 16;
  localparam int T_RP  = 16;
  localparam int T_RRD = 4;
  localparam int T_RAS = 39;

  logic clk, rst, config_done, req_valid, req_rdy_o, cas_rdy;
  logic [1:0] req_rw, req_bg, req_ba;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic cmd_valid_o, cas_valid_o, act_idle_o;
  logic [1:0] cmd_type_o, cmd_bg_o, cmd_ba_o, cas_rw_o, cas_bg_o, cas_ba_o;
  logic [ROW_W-1:0] cmd_row_o;
  logic [COL_W-1:0] cas_col_o;

  ddr_act_scheduler #(
    .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RRD(T_RRD), .T_RAS(T_RAS)
  ) dut (
    .clock_i(clk), .reset_i(rst), .config_done_i(config_done),
    .req_valid_i(req_valid), .req_rdy_o(req_rdy_o), .req_rw_i(req_rw),
    .req_bg_i(req_bg), .req_ba_i(req_ba), .req_row_i(req_row), .req_col_i(req_col),
    .cmd_valid_o(cmd_valid_o), .cmd_type_o(cmd_type_o), .cmd_bg_o(cmd_bg_o),
    .cmd_ba_o(cmd_ba_o), .cmd_row_o(cmd_row_o),
    .cas_valid_o(cas_valid_o), .cas_rdy_i(cas_rdy), .cas_rw_o(cas_rw_o),
    .cas_bg_o(cas_bg_o), .cas_ba_o(cas_ba_o), .cas_col_o(cas_col_o),
    .act_idle_o(act_idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 01 ACT, 10 PRE, 11 CAS handoff
  typedef struct {
    logic [1:0]       kind;
    logic [1:0]       bg;
    logic [1:0]       ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [1:0]       rw;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int nchk = 0;
  int nerr = 0;
  int rdy_mode = 0;

  // Reference model: absolute cycle of each bank's last ACT and of the last ACT overall.
  bit               open_v[16];
  logic [ROW_W-1:0] open_row[16];
  int               act_t[16];
  int               last_act;

  function automatic logic [63:0] pk(input logic [1:0] kind, input logic [1:0] bg,
                                     input logic [1:0] ba, input logic [ROW_W-1:0] row,
                                     input logic [COL_W-1:0] col, input logic [1:0] rw,
                                     input int c);
    logic [15:0] c16;
    c16 = c[15:0];
    return {15'd0, kind, bg, ba, row, col, rw, c16};
  endfunction

  function automatic logic [63:0] out_vec();
    return {23'd0, req_rdy_o, cmd_valid_o, cmd_type_o, cmd_bg_o, cmd_ba_o, cmd_row_o,
            cas_valid_o, cas_rw_o, cas_bg_o, cas_ba_o, cas_col_o, act_idle_o};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [1:0] bg, input logic [1:0] ba,
                          input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                          input logic [1:0] rw, input int c);
    exp_t e;
    e.kind = kind; e.bg = bg; e.ba = ba; e.row = row; e.col = col; e.rw = rw; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      open_v[i] = 1'b0;
      open_row[i] = '0;
      act_t[i] = -1000;
    end
    last_act = -1000;
  endtask

  task automatic model_accept(input int n, input logic [1:0] bg, input logic [1:0] ba,
                              input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                              input logic [1:0] rw);
    int b, t, pre, act;
    b = int'({bg, ba});
    if (open_v[b] && open_row[b] == row) begin
      push_exp(2'b11, bg, ba, '0, col, rw, n + 2);
    end else begin
      t = n + 2;
      if (open_v[b]) begin
        pre = imax(n + 2, act_t[b] + T_RAS);
        push_exp(2'b10, bg, ba, '0, '0, 2'b00, pre);
        t = pre + T_RP;
      end
      act = imax(t, last_act + T_RRD);
      push_exp(2'b01, bg, ba, row, '0, 2'b00, act);
      last_act = act;
      act_t[b] = act;
      open_v[b] = 1'b1;
      open_row[b] = row;
      push_exp(2'b11, bg, ba, '0, col, rw, act + T_RCD);
    end
  endtask

  task automatic send(input logic [1:0] bg, input logic [1:0] ba, input logic [ROW_W-1:0] row,
                      input logic [COL_W-1:0] col, input logic [1:0] rw);
    int w;
    @(negedge clk);
    req_bg = bg; req_ba = ba; req_row = row; req_col = col; req_rw = rw;
    req_valid = 1'b1;
    w = 0;
    while (!req_rdy_o && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("req_accept_in_time", {63'd0, req_rdy_o}, 64'd1);
    if (req_rdy_o) begin
      check("accept_after_previous_done", {63'd0, exp_q.size() == 0}, 64'd1);
      model_accept(cyc, bg, ba, row, col, rw);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !act_idle_o) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_in_time", {63'd0, exp_q.size() == 0 && act_idle_o}, 64'd1);
  endtask

  initial begin
    cas_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       cas_rdy = ($urandom_range(0, 3) != 0);
        1:       cas_rdy = 1'b0;
        default: cas_rdy = 1'b1;
      endcase
    end
  end

  // Monitor: every command pulse and every new handoff pops the scoreboard.
  logic        pend = 1'b0;
  logic [63:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (cmd_valid_o) begin
        check("cmd_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("cmd", pk(cmd_type_o, cmd_bg_o, cmd_ba_o, cmd_row_o, '0, 2'b00, cyc),
                pk(mon_e.kind, mon_e.bg, mon_e.ba, mon_e.row, '0, 2'b00, mon_e.cyc));
        end
      end
      if (cas_valid_o && !pend) begin
        check("cas_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("cas", pk(2'b11, cas_bg_o, cas_ba_o, '0, cas_col_o, cas_rw_o, cyc),
                pk(mon_e.kind, mon_e.bg, mon_e.ba, '0, mon_e.col, mon_e.rw, mon_e.cyc));
        end
      end
      if (pend)
        check("cas_stable", cas_valid_o ? pk(2'b11, cas_bg_o, cas_ba_o, '0, cas_col_o, cas_rw_o, 0) : 64'd0,
              held);
      if (cas_valid_o)
        check("req_rdy_while_busy", {63'd0, req_rdy_o}, 64'd0);
      pend <= cas_valid_o && !cas_rdy;
      held <= pk(2'b11, cas_bg_o, cas_ba_o, '0, cas_col_o, cas_rw_o, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; config_done = 1'b0; req_valid = 1'b0;
    req_rw = '0; req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_without_config", out_vec(), 64'd1);
    config_done = 1'b1;
    @(negedge clk);
    check("req_rdy_after_config", {63'd0, req_rdy_o}, 64'd1);

    // Closed bank then row hit, closed bank elsewhere, two row misses, tRRD.
    rdy_mode = 2;
    send(2'd0, 2'd0, 15'd5, 10'h011, RW_WRITE);
    send(2'd0, 2'd0, 15'd5, 10'h022, RW_READ);
    send(2'd1, 2'd2, 15'h1A, 10'h033, RW_WRITE);
    send(2'd0, 2'd0, 15'd3, 10'h044, RW_READ);
    send(2'd0, 2'd0, 15'd4, 10'h055, RW_WRITE);
    send(2'd0, 2'd1, 15'd9, 10'h066, RW_READ);
    wait_drain();

    // Backpressure on a row hit.
    rdy_mode = 1;
    send(2'd0, 2'd0, 15'd4, 10'h077, RW_READ);
    w = 0;
    while (!cas_valid_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_cas_valid_seen", {63'd0, cas_valid_o}, 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_req_rdy_low", {63'd0, req_rdy_o}, 64'd0);
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", {62'd0, req_rdy_o, cas_valid_o}, 64'd2);

    // config_done drops while busy: request completes, nothing new accepted.
    rdy_mode = 0;
    send(2'd1, 2'd2, 15'h1B, 10'h088, RW_READ);
    config_done = 1'b0;
    wait_drain();
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_accept_without_config", {62'd0, req_rdy_o, act_idle_o}, 64'd1);
    end
    req_valid = 1'b0;
    config_done = 1'b1;

    // Reset during WAIT_RCD, then the same row needs a fresh ACT.
    send(2'd3, 2'd3, 15'h55, 10'h099, RW_WRITE);
    w = 0;
    while (exp_q.size() != 1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("act_before_reset", {63'd0, exp_q.size() == 1}, 64'd1);
    repeat (5) @(negedge clk);
    config_done = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("reset_mid_op_outputs", out_vec(), 64'd1);
    rst = 1'b0;
    config_done = 1'b1;
    send(2'd3, 2'd3, 15'h55, 10'h0AA, RW_READ);
    wait_drain();

    // Randomized traffic over a few banks and rows.
    for (int i = 0; i < 40; i++) begin
      rdy_mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
      send(2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 15'($urandom_range(0, 2)),
           10'($urandom_range(0, 1023)), ($urandom_range(0, 1) != 0) ? RW_READ : RW_WRITE);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rdy_mode = 0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
